// File: rtl/int_decl_emitter.sv
// int_decl_emitter
// Emits one C integer declaration of the form "int v0,v1,...,vK;" as an ASCII
// byte stream over a valid/ready handshake, one byte per accepted transfer.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      request one declaration (sampled only while idle)
//   count      identifier count, latched on an accepted start (1..MAXN)
//   out_valid  out_char holds a byte on offer
//   out_char   ASCII byte on offer
//   out_ready  consumer accepts out_char when out_valid && out_ready
//   busy       high from the cycle after an accepted start until ';' is taken
//   done       one-cycle pulse after ';' is accepted
//   err        one-cycle pulse for a start with an illegal count
//
// Build option:
//   INT_DECL_EMITTER_SPACE_EN  when defined, a space follows every comma
//                              ("int v0, v1;").
//
// States:
//   IDLE | waiting for start
//   KW_I | offering 'i'
//   KW_N | offering 'n'
//   KW_T | offering 't'
//   SP   | offering ' ' after the keyword
//   PFX  | offering PREFIX before an index
//   TENS | offering tens digit (only when tens != 0)
//   ONES | offering ones digit
//   SEP  | offering ','
//   SP2  | offering ' ' after ',' (space option only)
//   SEMI | offering ';'

module int_decl_emitter #(
  parameter logic [7:0] PREFIX = 8'h76,
  parameter int         MAXN   = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] count,
  output logic       out_valid,
  output logic [7:0] out_char,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] CH_I    = 8'h69;
  localparam logic [7:0] CH_N    = 8'h6E;
  localparam logic [7:0] CH_T    = 8'h74;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_SEMI = 8'h3B;

  typedef enum logic [3:0] {
    S_IDLE,
    S_KW_I,
    S_KW_N,
    S_KW_T,
    S_SP,
    S_PFX,
    S_TENS,
    S_ONES,
    S_SEP,
`ifdef INT_DECL_EMITTER_SPACE_EN
    S_SP2,
`endif
    S_SEMI
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [6:0] idx_q, idx_d;     // binary copy of the BCD index, for the end test
  logic [6:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic [7:0] char_q, char_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       count_ok;

  function automatic logic [7:0] digit(input logic [3:0] d);
    return 8'h30 | {4'h0, d};
  endfunction

  assign count_ok = (count != 7'd0) && (count <= 7'(MAXN));

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    char_d  = char_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (state_q == S_IDLE) begin
      if (start) begin
        if (count_ok) begin
          cnt_d   = count;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          idx_d   = 7'd0;
          state_d = S_KW_I;
          valid_d = 1'b1;
          char_d  = CH_I;
          busy_d  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (out_ready) begin
      // every non-idle state holds out_valid, so ready alone means accepted
      unique case (state_q)
        S_KW_I: begin
          state_d = S_KW_N;
          char_d  = CH_N;
        end
        S_KW_N: begin
          state_d = S_KW_T;
          char_d  = CH_T;
        end
        S_KW_T: begin
          state_d = S_SP;
          char_d  = CH_SP;
        end
        S_SP: begin
          state_d = S_PFX;
          char_d  = PREFIX;
        end
        S_PFX: begin
          // skip the tens digit so single-digit indices carry no leading zero
          if (tens_q != 4'd0) begin
            state_d = S_TENS;
            char_d  = digit(tens_q);
          end else begin
            state_d = S_ONES;
            char_d  = digit(ones_q);
          end
        end
        S_TENS: begin
          state_d = S_ONES;
          char_d  = digit(ones_q);
        end
        S_ONES: begin
          if ((idx_q + 7'd1) == cnt_q) begin
            state_d = S_SEMI;
            char_d  = CH_SEMI;
          end else begin
            idx_d = idx_q + 7'd1;
            if (ones_q == 4'd9) begin
              ones_d = 4'd0;
              tens_d = tens_q + 4'd1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
            state_d = S_SEP;
            char_d  = CH_COMMA;
          end
        end
`ifdef INT_DECL_EMITTER_SPACE_EN
        S_SEP: begin
          state_d = S_SP2;
          char_d  = CH_SP;
        end
        S_SP2: begin
          state_d = S_PFX;
          char_d  = PREFIX;
        end
`else
        S_SEP: begin
          state_d = S_PFX;
          char_d  = PREFIX;
        end
`endif
        S_SEMI: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          char_d  = 8'h00;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          char_d  = 8'h00;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      idx_q   <= 7'd0;
      cnt_q   <= 7'd0;
      valid_q <= 1'b0;
      char_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      char_q  <= char_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_char  = char_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_int_decl_emitter.sv
module tb_int_decl_emitter;

  logic       clk;
  logic       reset;
  logic       start;
  logic [6:0] count;
  logic       out_valid;
  logic [7:0] out_char;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  int_decl_emitter dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .count     (count),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    n;
    bit    toggle;
    string exp;
    string name;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  // With the space option every comma is followed by a space.
  function automatic string expand(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      r = {r, s.substr(i, i)};
`ifdef INT_DECL_EMITTER_SPACE_EN
      if (s[i] == ",") r = {r, " "};
`endif
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_decl(input int n, input bit tog, input string exp_raw, input string name);
    string exp;
    string got;
    int    cycles;
    bit    fin;
    bit    prev_stall;
    logic [7:0] prev_char;
    exp = expand(exp_raw);
    count = 7'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, " first valid"}, {31'd0, out_valid}, 32'd1);
    check({name, " first char"}, {24'd0, out_char}, 32'h69);
    check({name, " busy"}, {31'd0, busy}, 32'd1);
    got = "";
    cycles = 0;
    fin = 1'b0;
    prev_stall = 1'b0;
    prev_char = 8'h00;
    for (int c = 0; c < 400 && !fin; c++) begin
      out_ready = tog ? (c % 2 == 0) : 1'b1;
      if (prev_stall) check({name, " stall stable"}, {24'd0, out_char}, {24'd0, prev_char});
      prev_stall = out_valid && !out_ready;
      prev_char  = out_char;
      if (out_valid && out_ready) begin
        got = $sformatf("%s%c", got, out_char);
        if (out_char == 8'h3B) fin = 1'b1;
      end
      cycles++;
      @(negedge clk);
    end
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: no ';' within cycle budget, got \"%s\"", name, got);
    end
    check_str({name, " stream"}, got, exp);
    if (!tog) check({name, " cycles"}, cycles, exp.len());
    check({name, " done"}, {31'd0, done}, 32'd1);
    check({name, " busy after"}, {31'd0, busy}, 32'd0);
    check({name, " valid after"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic bad_start(input int n, input string name);
    count = 7'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, " err"}, {31'd0, err}, 32'd1);
    check({name, " valid"}, {31'd0, out_valid}, 32'd0);
    check({name, " busy"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({name, " err pulse"}, {31'd0, err}, 32'd0);
    check({name, " still idle"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1,  1'b0, "int v0;", "n1"};
    vecs[1] = '{3,  1'b1, "int v0,v1,v2;", "n3_tog"};
    vecs[2] = '{12, 1'b0, "int v0,v1,v2,v3,v4,v5,v6,v7,v8,v9,v10,v11;", "n12"};
    vecs[3] = '{10, 1'b1, "int v0,v1,v2,v3,v4,v5,v6,v7,v8,v9;", "n10_tog"};
    vecs[4] = '{2,  1'b0, "int v0,v1;", "n2"};

    reset = 1'b0;
    start = 1'b0;
    count = 7'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset valid", {31'd0, out_valid}, 32'd0);
    check("reset char", {24'd0, out_char}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("ready while idle", {31'd0, out_valid}, 32'd0);

    // consecutive entries start in the previous done cycle (back-to-back)
    for (int i = 0; i < 5; i++) begin
      run_decl(vecs[i].n, vecs[i].toggle, vecs[i].exp, vecs[i].name);
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("done pulse width", {31'd0, done}, 32'd0);

    bad_start(0, "count0");
    bad_start(100, "count100");
    bad_start(127, "count127");

    // abort mid-stream with reset after six bytes
    out_ready = 1'b1;
    count = 7'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre-abort char", {24'd0, out_char}, 32'h2C);
    reset = 1'b0;
    #1;
    check("abort valid", {31'd0, out_valid}, 32'd0);
    check("abort char", {24'd0, out_char}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post-abort idle", {31'd0, out_valid}, 32'd0);
    run_decl(2, 1'b0, "int v0,v1;", "after_reset");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
